// File: rtl/au_cmd_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// au_cmd_sequencer_pkg
// Shared definitions for the arithmetic-unit command sequencer:
//   - host command opcodes (cmd_op)
//   - unit register-select codes (au_uio[4:3])
//   - au_uio bit positions and a packed field struct for the encoder
//   - FSM state codes
//   - operand extension helper
// ----------------------------------------------------------------------------
package au_cmd_sequencer_pkg;

    // Host opcodes; the same 2-bit value is forwarded to the unit during EXEC.
    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b01;
    localparam logic [1:0] OP_SUB     = 2'b10;
    localparam logic [1:0] OP_MUL     = 2'b11;

    // Unit register-select codes.
    localparam logic [1:0] REG_A_LO = 2'b00;
    localparam logic [1:0] REG_A_HI = 2'b01;
    localparam logic [1:0] REG_B_LO = 2'b10;
    localparam logic [1:0] REG_B_HI = 2'b11;

    // au_uio bit positions. Bit 0 is always driven 0.
    localparam int UIO_C_BIT   = 7;
    localparam int UIO_OP_LSB  = 5;
    localparam int UIO_REG_LSB = 3;
    localparam int UIO_RW_BIT  = 2;
    localparam int UIO_S_BIT   = 1;

    // Control fields packed into au_uio by au_uio_encoder.
    typedef struct packed {
        logic       c;      // signed operands
        logic [1:0] op;     // unit operation
        logic [1:0] sel;    // register select
        logic       rw;     // 1 = byte load
        logic       s;      // 1 = unit active; 0 clears the unit counter
    } uio_fields_t;

    // FSM state codes.
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_LD0    = 4'd1;   // B_hi
    localparam state_t ST_LD1    = 4'd2;   // B_lo
    localparam state_t ST_LD2    = 4'd3;   // A_hi
    localparam state_t ST_LD3    = 4'd4;   // A_lo
    localparam state_t ST_EXEC   = 4'd5;
    localparam state_t ST_SETTLE = 4'd6;
    localparam state_t ST_RD_LO  = 4'd7;
    localparam state_t ST_RD_HI  = 4'd8;
    localparam state_t ST_RESP   = 4'd9;

    // Upper byte of the 16-bit extension of an 8-bit operand.
    function automatic logic [7:0] ext8(input logic [7:0] val, input logic is_signed);
        return is_signed ? {8{val[7]}} : 8'h00;
    endfunction

endpackage

// File: rtl/au_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// au_cmd_sequencer_if
// Host-side command/response bundle of the sequencer.
//   cmd_*  : command request (valid/ready), opcode, signedness, operands
//   rsp_*  : response (valid/ready), 16-bit result, ovf/neg/err/timeout flags
// Modports:
//   master : host side (drives commands, consumes responses)
//   slave  : sequencer side
// ----------------------------------------------------------------------------
interface au_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_signed;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_ovf;
    logic        rsp_neg;
    logic        rsp_err;
    logic        rsp_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_signed, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_ovf, rsp_neg, rsp_err, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_signed, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_ovf, rsp_neg, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/au_cmd_sequencer_au_uio_encoder.sv
// ----------------------------------------------------------------------------
// au_uio_encoder
// Combinational packing of the unit control fields into the au_uio byte:
//   [7] C, [6:5] op, [4:3] reg, [2] RW, [1] S, [0] = 0
// Ports:
//   i_fields : control fields
//   o_uio    : packed control byte for the unit
// ----------------------------------------------------------------------------
module au_uio_encoder
    import au_cmd_sequencer_pkg::*;
(
    input  uio_fields_t i_fields,
    output logic [7:0]  o_uio
);

    always_comb begin
        o_uio                      = '0;
        o_uio[UIO_C_BIT]           = i_fields.c;
        o_uio[UIO_OP_LSB +: 2]     = i_fields.op;
        o_uio[UIO_REG_LSB +: 2]    = i_fields.sel;
        o_uio[UIO_RW_BIT]          = i_fields.rw;
        o_uio[UIO_S_BIT]           = i_fields.s;
    end

endmodule

// File: rtl/au_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// au_cmd_sequencer
// Command front-end for the 8/16-bit arithmetic unit. Takes one ADD/SUB/MUL
// command per handshake, loads the unit registers byte by byte, runs the
// exec phase, reads the 16-bit result back and returns it with flags.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   host        : command/response bundle (slave side)
//   au_ui       : data byte to unit ui_in
//   au_uio      : control byte to unit uio_in
//   au_uo       : unit byte output
//   au_done     : unit finished (F)
//   au_ovf      : unit overflow (P)
//   au_neg      : unit negative (N)
//   au_err      : unit error
// ----------------------------------------------------------------------------
module au_cmd_sequencer
    import au_cmd_sequencer_pkg::*;
#(
    parameter int ADDSUB_CYCLES = 20,
    parameter int MUL_TIMEOUT   = 160,
    parameter int READ_LAT      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    au_cmd_sequencer_if.slave   host,
    output logic [7:0]          au_ui,
    output logic [7:0]          au_uio,
    input  logic [7:0]          au_uo,
    input  logic                au_done,
    input  logic                au_ovf,
    input  logic                au_neg,
    input  logic                au_err
);

    // Wait counter reload values: the counter counts down to 0 on the
    // final cycle of a state, so each reload is the cycle count minus one.
    localparam logic [7:0] LP_ADDSUB_LOAD = 8'(ADDSUB_CYCLES - 1);
    localparam logic [7:0] LP_MUL_LOAD    = 8'(MUL_TIMEOUT - 1);
    localparam logic [7:0] LP_READ_LOAD   = 8'(READ_LAT - 1);

    state_t      r_state;
    logic [7:0]  r_wait;
    logic [1:0]  r_op;
    logic        r_signed;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_result;
    logic        r_ovf;
    logic        r_neg;
    logic        r_err;
    logic        r_timeout;
    logic        r_cmd_ready;

    logic        w_accept;
    logic        w_wait_done;
    logic        w_exec_last;
    uio_fields_t w_fields;
    logic [7:0]  w_ui;

    assign w_accept    = (r_state == ST_IDLE) && r_cmd_ready && host.cmd_valid;
    assign w_wait_done = (r_wait == 8'd0);
    // MUL ends on au_done or when the timeout budget is used up.
    assign w_exec_last = (r_op == OP_MUL) ? (au_done || w_wait_done) : w_wait_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_op        <= '0;
            r_signed    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_neg       <= 1'b0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= host.cmd_op;
                        r_signed    <= host.cmd_signed;
                        r_a         <= host.cmd_a;
                        r_b         <= host.cmd_b;
                        r_result    <= '0;
                        r_ovf       <= 1'b0;
                        r_neg       <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_wait      <= '0;
                        r_cmd_ready <= 1'b0;
                        // An illegal opcode never touches the unit.
                        if (host.cmd_op == OP_ILLEGAL) begin
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= ST_LD0;
                        end
                    end else begin
                        // Also covers the first cycle after reset release.
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_LD0: r_state <= ST_LD1;
                ST_LD1: r_state <= ST_LD2;
                ST_LD2: r_state <= ST_LD3;
                ST_LD3: begin
                    r_state <= ST_EXEC;
                    r_wait  <= (r_op == OP_MUL) ? LP_MUL_LOAD : LP_ADDSUB_LOAD;
                end
                ST_EXEC: begin
                    if (au_err) begin
                        r_err <= 1'b1;
                    end
                    if (w_exec_last) begin
                        r_ovf     <= au_ovf;
                        r_neg     <= au_neg;
                        r_timeout <= (r_op == OP_MUL) && !au_done;
                        r_state   <= ST_SETTLE;
                        r_wait    <= '0;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                ST_SETTLE: begin
                    r_state <= ST_RD_LO;
                    r_wait  <= LP_READ_LOAD;
                end
                ST_RD_LO: begin
                    if (w_wait_done) begin
                        r_result[7:0] <= au_uo;
                        r_state       <= ST_RD_HI;
                        r_wait        <= LP_READ_LOAD;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                ST_RD_HI: begin
                    if (w_wait_done) begin
                        r_result[15:8] <= au_uo;
                        r_state        <= ST_RESP;
                        r_wait         <= '0;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (host.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Unit control stream, decoded from the registered state so au_ui/au_uio
    // only change on clock edges.
    always_comb begin
        w_fields = '0;
        w_ui     = '0;
        case (r_state)
            ST_LD0: begin
                w_fields.c   = r_signed;
                w_fields.sel = REG_B_HI;
                w_fields.rw  = 1'b1;
                w_fields.s   = 1'b1;
                w_ui         = (r_op == OP_MUL) ? 8'h00 : ext8(r_a, r_signed);
            end
            ST_LD1: begin
                w_fields.c   = r_signed;
                w_fields.sel = REG_B_LO;
                w_fields.rw  = 1'b1;
                w_fields.s   = 1'b1;
                w_ui         = (r_op == OP_MUL) ? 8'h00 : r_a;
            end
            ST_LD2: begin
                w_fields.c   = r_signed;
                w_fields.sel = REG_A_HI;
                w_fields.rw  = 1'b1;
                w_fields.s   = 1'b1;
                w_ui         = ext8(r_a, r_signed);
            end
            ST_LD3: begin
                w_fields.c   = r_signed;
                w_fields.sel = REG_A_LO;
                w_fields.rw  = 1'b1;
                w_fields.s   = 1'b1;
                w_ui         = r_a;
            end
            ST_EXEC: begin
                w_fields.c  = r_signed;
                w_fields.op = r_op;
                w_fields.s  = 1'b1;
                w_ui        = r_b;
            end
            ST_RD_LO: w_fields.sel = REG_B_LO;
            ST_RD_HI: w_fields.sel = REG_B_HI;
            default: ;
        endcase
    end

    au_uio_encoder u_uio_encoder (
        .i_fields (w_fields),
        .o_uio    (au_uio)
    );

    assign au_ui            = w_ui;
    assign host.cmd_ready   = r_cmd_ready;
    assign host.rsp_valid   = (r_state == ST_RESP);
    assign host.rsp_result  = r_result;
    assign host.rsp_ovf     = r_ovf;
    assign host.rsp_neg     = r_neg;
    assign host.rsp_err     = r_err;
    assign host.rsp_timeout = r_timeout;

endmodule

// File: doc/au_cmd_sequencer.md
Name: au_cmd_sequencer

Overview:
- Upstream command front-end for the 8-bit/16-bit arithmetic unit (ADD/SUB/shift-add MUL core with 16-bit registers A and B).
- Accepts one operation per valid/ready handshake and drives the unit's ui_in/uio_in control stream: byte loads, exec strobe, byte readback.
- Returns a 16-bit result plus flags over a valid/ready response port.
- Replaces manual pin-toggling by the host; one command in flight at a time.

Parameters:
- ADDSUB_CYCLES, 20, exec cycles with S=1 for ADD/SUB.
- MUL_TIMEOUT, 160, max exec cycles waiting for au_done before abort.
- READ_LAT, 2, cycles a read select is held before au_uo is captured (≥1).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, high only in IDLE.
- cmd_op, in, 2, 01 ADD, 10 SUB, 11 MUL, 00 illegal.
- cmd_signed, in, 1, two's-complement operands (drives unit C bit).
- cmd_a, in, 8, first operand.
- cmd_b, in, 8, second operand.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_result, out, 16, result word.
- rsp_ovf, out, 1, unit P flag latched at end of exec.
- rsp_neg, out, 1, unit N flag latched at end of exec.
- rsp_err, out, 1, sticky unit error, or illegal op.
- rsp_timeout, out, 1, MUL did not finish within MUL_TIMEOUT.
- au_ui, out, 8, to unit ui_in.
- au_uio, out, 8, to unit uio_in: [7]C, [6:5]op, [4:3]reg, [2]RW, [1]S, [0]=0.
- au_uo, in, 8, unit byte output.
- au_done, in, 1, unit F flag.
- au_ovf, in, 1, unit P flag.
- au_neg, in, 1, unit N flag.
- au_err, in, 1, unit error output.

Behaviour:
- Reset, async on rst_n low: state IDLE; all outputs 0 except cmd_ready=1 after release. au_uio=0 (S=0 clears unit counter).
- Register-select encoding on au_uio[4:3]: 00 A_lo, 01 A_hi, 10 B_lo, 11 B_hi.
- Accept on cmd_valid&&cmd_ready. Latch op, signed, a, b; clear flags; cmd_ready drops the next cycle.
- Illegal op 00: go straight to RESP. rsp_result=0, rsp_err=1, no unit traffic.
- LD0..LD3, one cycle each, op=00, RW=1, S=1, C=signed:
  - A_lo←a, A_hi←ext(a).
  - B_lo, B_hi←a/ext(a) for ADD/SUB; B_lo, B_hi←0 for MUL.
  - ext = 8 copies of a[7] if signed, else 0x00.
- EXEC: op=cmd_op, RW=0, S=1, au_ui=b, held stable.
  - ADD/SUB: exactly ADDSUB_CYCLES cycles.
  - MUL: until au_done sampled high; exec is at least 1 cycle, at most MUL_TIMEOUT cycles.
  - Timeout: set rsp_timeout, continue to readback.
  - au_err sampled high in any EXEC cycle sets sticky rsp_err.
  - au_ovf/au_neg latched on the last EXEC cycle.
- SETTLE: 1 cycle, au_uio=0.
- RD_LO: au_uio reg=10, RW=0, S=0 for READ_LAT cycles; rsp_result[7:0]←au_uo on the last cycle.
- RD_HI: same with reg=11 into rsp_result[15:8].
- RESP: rsp_valid=1, outputs held stable until rsp_ready. On handshake go to IDLE; cmd_ready rises the following cycle. No same-cycle accept.
- Latency, accept edge to rsp_valid:
  - ADD/SUB: 4+ADDSUB_CYCLES+1+2·READ_LAT, default 29.
  - MUL: 4+k+1+2·READ_LAT, where k is the exec cycle count.
- Single shared wait counter, 8 bits, reloaded on each state entry. It must not wrap for MUL_TIMEOUT ≤ 255.
- rst_n low mid-operation aborts immediately to IDLE. Any response in progress is discarded.
- cmd_valid while busy is ignored; no queueing.

Decomposition:
- Shared package holds:
  - cmd_op encodings.
  - Register-select codes.
  - au_uio bit positions.
  - State enum.
- One sub-module, au_uio_encoder: combinational packing of {C, op, reg, RW, S} into au_uio.
- The FSM, wait counter and response registers stay in au_cmd_sequencer.

Test Plan:
- Signed ADD a=0xFD (−3), b=0x05 → rsp_result=0x0002, ovf/neg per unit model, rsp_valid exactly 29 cycles after accept. au_uio trace LD: 0x9E, 0x96, 0x8E, 0x86.
- Unsigned SUB a=0x10, b=0x20 → unit model result 0xFFF0; rsp_neg=0; au_uio exec word 0x42 for 20 cycles.
- MUL a=0x0C, b=0x0A, model asserts au_done after 128 cycles → rsp_result=0x0078, rsp_timeout=0.
- MUL with au_done held low → EXEC ends after 160 cycles, rsp_timeout=1, readback still performed.
- cmd_op=00 → rsp_valid 1 cycle after accept, rsp_err=1, result 0x0000, au_uio stays 0.
- Backpressure and reset: hold rsp_ready=0 for 10 cycles, outputs stable and cmd_ready=0. Separately, assert rst_n low mid-EXEC → all outputs 0, cmd_ready=1 after release, next command completes correctly.
